// File: rtl/timer_pkg.sv
// Shared state and mode encodings for the minutes:seconds timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } timer_state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up/down counter with synchronous load and a terminal-value flag.
module mod_counter #(
  parameter int W   = 6,
  parameter int MOD = 60
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  assign wrap = up ? (q == MAX) : (q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      if (up) q <= (q == MAX) ? '0 : q + 1'b1;
      else    q <= (q == '0) ? MAX : q - 1'b1;
    end
  end

endmodule

// File: rtl/timer_mmss.sv
// Minutes:seconds stopwatch/countdown with editable presets and a finish flag.
module timer_mmss
  import timer_pkg::*;
#(
  parameter int W       = 6,
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         enable,
  input  logic         mode,
  input  logic         set,
  input  logic         inc_sec,
  input  logic         inc_min,
  input  logic         start,
  input  logic         clear,
  output logic [W-1:0] sec,
  output logic [W-1:0] min,
  output logic         running,
  output logic         finish,
  output logic         finish_pulse
);

  if (SEC_MOD > (2 ** W) || MIN_MOD > (2 ** W)) begin : g_width_check
    $error("timer_mmss: SEC_MOD/MIN_MOD exceed 2**W");
  end

  localparam logic [W-1:0] SEC_MAX = W'(SEC_MOD - 1);
  localparam logic [W-1:0] MIN_MAX = W'(MIN_MOD - 1);

  timer_state_t state, state_nxt;
  logic [W-1:0] pre_sec, pre_min, pre_sec_nxt, pre_min_nxt;
  logic [1:0]   inc_sec_d, inc_min_d;
  logic         sec_edge, min_edge;
  logic         cnt_up, cnt_en, cnt_load, sec_wrap, min_wrap, fpulse_nxt;
  logic [W-1:0] load_sec, load_min;

  // Two-stage edge register: the edge is seen one cycle after the input rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_sec_d <= '0;
      inc_min_d <= '0;
    end else begin
      inc_sec_d <= {inc_sec_d[0], inc_sec};
      inc_min_d <= {inc_min_d[0], inc_min};
    end
  end

  assign sec_edge = inc_sec_d[0] & ~inc_sec_d[1];
  assign min_edge = inc_min_d[0] & ~inc_min_d[1];

  always_comb begin
    pre_sec_nxt = pre_sec;
    pre_min_nxt = pre_min;
    if (state == SET && !clear) begin
      if (sec_edge) pre_sec_nxt = (pre_sec == SEC_MAX) ? '0 : pre_sec + 1'b1;
      if (min_edge) pre_min_nxt = (pre_min == MIN_MAX) ? '0 : pre_min + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_sec <= '0;
      pre_min <= '0;
    end else begin
      pre_sec <= pre_sec_nxt;
      pre_min <= pre_min_nxt;
    end
  end

  assign cnt_up = (mode == MODE_UP);

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_load  = 1'b0;
    load_sec  = pre_sec_nxt;
    load_min  = pre_min_nxt;
    if (clear) begin
      state_nxt = IDLE;
      cnt_load  = 1'b1;
      if (cnt_up) begin
        load_sec = '0;
        load_min = '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (set) begin
            state_nxt = SET;
            cnt_load  = 1'b1;
          end else if (start && enable) begin
            cnt_load = 1'b1;
            if (cnt_up) begin
              state_nxt = RUN;
              load_sec  = '0;
              load_min  = '0;
            end else if (pre_sec != '0 || pre_min != '0) begin
              state_nxt = RUN;
            end else begin
              state_nxt = DONE;
            end
          end
        end
        SET: begin
          cnt_load = 1'b1;
          if (!set) begin
            state_nxt = IDLE;
            if (cnt_up) begin
              load_sec = '0;
              load_min = '0;
            end
          end
        end
        RUN: begin
          // Both fields at their terminal value: saturate (up) or already 0:00 (down).
          if (tick && enable) begin
            if (sec_wrap && min_wrap) begin
              state_nxt = DONE;
            end else begin
              cnt_en = 1'b1;
              if (!cnt_up && min_wrap && sec == W'(1)) state_nxt = DONE;
            end
          end
        end
        DONE: state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign fpulse_nxt = (state_nxt == DONE) && (state != DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      finish_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      finish_pulse <= fpulse_nxt;
    end
  end

  assign running = (state == RUN);
  assign finish  = (state == DONE);

  mod_counter #(.W(W), .MOD(SEC_MOD)) u_sec (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (cnt_en),
    .up       (cnt_up),
    .load     (cnt_load),
    .load_val (load_sec),
    .q        (sec),
    .wrap     (sec_wrap)
  );

  mod_counter #(.W(W), .MOD(MIN_MOD)) u_min (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (cnt_en & sec_wrap),
    .up       (cnt_up),
    .load     (cnt_load),
    .load_val (load_min),
    .q        (min),
    .wrap     (min_wrap)
  );

endmodule

// File: tb/tb_timer_mmss.sv
// Bench for timer_mmss: directed scenarios then random traffic, checked every cycle
// against a model that keeps the count as total seconds.
module tb_timer_mmss;

  localparam int W       = 6;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int MAX_TOT = SEC_MOD * MIN_MOD - 1;

  localparam int T_IDLE = 0;
  localparam int T_SET  = 1;
  localparam int T_RUN  = 2;
  localparam int T_DONE = 3;

  logic         clk = 1'b0;
  logic         reset_n, tick, enable, mode, set, inc_sec, inc_min, start, clear;
  logic [W-1:0] sec, min;
  logic         running, finish, finish_pulse;

  int nvec = 0;
  int nerr = 0;

  int m_state, m_cnt, m_pre_s, m_pre_m;
  bit m_pulse;
  bit hs1, hs2, hm1, hm2;

  timer_mmss #(.W(W), .SEC_MOD(SEC_MOD), .MIN_MOD(MIN_MOD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .enable       (enable),
    .mode         (mode),
    .set          (set),
    .inc_sec      (inc_sec),
    .inc_min      (inc_min),
    .start        (start),
    .clear        (clear),
    .sec          (sec),
    .min          (min),
    .running      (running),
    .finish       (finish),
    .finish_pulse (finish_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp)
    else begin
      nerr++;
      $error("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = T_IDLE;
    m_cnt   = 0;
    m_pre_s = 0;
    m_pre_m = 0;
    m_pulse = 0;
    hs1 = 0; hs2 = 0; hm1 = 0; hm2 = 0;
  endtask

  task automatic model_edge();
    int  prev, ptot;
    bit  es, em;
    es = hs1 && !hs2;
    em = hm1 && !hm2;
    hs2 = hs1; hs1 = inc_sec;
    hm2 = hm1; hm1 = inc_min;
    prev = m_state;
    if (!clear && m_state == T_SET) begin
      if (es) m_pre_s = (m_pre_s + 1) % SEC_MOD;
      if (em) m_pre_m = (m_pre_m + 1) % MIN_MOD;
    end
    ptot = m_pre_m * SEC_MOD + m_pre_s;
    if (clear) begin
      m_state = T_IDLE;
      m_cnt   = mode ? ptot : 0;
    end else begin
      case (m_state)
        T_IDLE:
          if (set) begin
            m_state = T_SET;
            m_cnt   = ptot;
          end else if (start && enable) begin
            if (!mode)          begin m_state = T_RUN;  m_cnt = 0;    end
            else if (ptot != 0) begin m_state = T_RUN;  m_cnt = ptot; end
            else                begin m_state = T_DONE; m_cnt = 0;    end
          end
        T_SET:
          if (set) m_cnt = ptot;
          else begin
            m_state = T_IDLE;
            m_cnt   = mode ? ptot : 0;
          end
        T_RUN:
          if (tick && enable) begin
            if (!mode) begin
              if (m_cnt == MAX_TOT) m_state = T_DONE;
              else m_cnt++;
            end else begin
              if (m_cnt == 0) m_state = T_DONE;
              else begin
                m_cnt--;
                if (m_cnt == 0) m_state = T_DONE;
              end
            end
          end
        default: ;
      endcase
    end
    m_pulse = (m_state == T_DONE) && (prev != T_DONE);
  endtask

  task automatic check_all();
    chk("sec",          sec,          m_cnt % SEC_MOD);
    chk("min",          min,          m_cnt / SEC_MOD);
    chk("running",      running,      m_state == T_RUN);
    chk("finish",       finish,       m_state == T_DONE);
    chk("finish_pulse", finish_pulse, m_pulse);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse_inc(input bit s, input bit m);
    inc_sec = s; inc_min = m;
    step();
    inc_sec = 0; inc_min = 0;
    step();
  endtask

  initial begin
    reset_n = 0; tick = 0; enable = 1; mode = 0; set = 0;
    inc_sec = 0; inc_min = 0; start = 0; clear = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk) reset_n = 1;

    // Set 2:03 then count down to 0:00
    set = 1; step();
    repeat (2) pulse_inc(0, 1);
    repeat (3) pulse_inc(1, 0);
    chk("set_disp_sec", sec, 3);
    chk("set_disp_min", min, 2);
    set = 0; mode = 1; step();
    start = 1; step(); start = 0;
    chk("cd_running", running, 1);
    tick = 1;
    repeat (122) step();
    chk("cd_not_done", finish, 0);
    step();
    chk("cd_zero_sec", sec, 0);
    chk("cd_zero_min", min, 0);
    chk("cd_finish", finish, 1);
    chk("cd_pulse_on", finish_pulse, 1);
    step();
    chk("cd_pulse_off", finish_pulse, 0);
    chk("cd_hold_sec", sec, 0);
    chk("cd_hold_finish", finish, 1);

    // Up count: 0:59 -> 1:00, then saturate at 59:59
    tick = 0; mode = 0; clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    tick = 1;
    repeat (59) step();
    chk("up_059_sec", sec, 59);
    step();
    chk("up_100_sec", sec, 0);
    chk("up_100_min", min, 1);
    repeat (MAX_TOT - 60) step();
    chk("up_max_sec", sec, 59);
    chk("up_max_min", min, 59);
    chk("up_max_run", running, 1);
    step();
    chk("sat_sec", sec, 59);
    chk("sat_min", min, 59);
    chk("sat_finish", finish, 1);

    // Pause
    tick = 0; clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    tick = 1; repeat (10) step();
    enable = 0; repeat (5) step();
    chk("pause_hold", sec, 10);
    enable = 1; step();
    chk("pause_resume", sec, 11);

    // Preset wrap: presets are 2:03, bring seconds to 59 then wrap
    tick = 0; mode = 1; clear = 1; step(); clear = 0;
    set = 1; step();
    repeat (56) pulse_inc(1, 0);
    chk("pre_59_sec", sec, 59);
    pulse_inc(1, 0);
    chk("pre_wrap_sec", sec, 0);
    chk("pre_wrap_min", min, 2);
    inc_sec = 1; repeat (10) step(); inc_sec = 0; step();
    chk("pre_held_sec", sec, 1);

    // Priority: preset 1:30, clear beats tick in RUN; set beats start in IDLE
    for (int i = 0; i < 59; i++) pulse_inc(i < 29, 1);
    chk("pre_130_sec", sec, 30);
    chk("pre_130_min", min, 1);
    set = 0; step();
    start = 1; step(); start = 0;
    tick = 1; repeat (3) step();
    clear = 1; step(); clear = 0; tick = 0;
    chk("clr_sec", sec, 30);
    chk("clr_min", min, 1);
    chk("clr_run", running, 0);
    set = 1; start = 1; step(); start = 0;
    chk("set_pri_run", running, 0);
    chk("set_pri_sec", sec, 30);

    // Reset mid-run at 0:45
    set = 0; mode = 0; step();
    start = 1; step(); start = 0;
    tick = 1; repeat (45) step(); tick = 0;
    chk("pre_rst_sec", sec, 45);
    #2 reset_n = 0;
    #1;
    model_reset();
    chk("arst_sec", sec, 0);
    chk("arst_min", min, 0);
    chk("arst_run", running, 0);
    chk("arst_finish", finish, 0);
    @(negedge clk) reset_n = 1;
    mode = 1; start = 1; step(); start = 0;
    chk("zero_cd_finish", finish, 1);
    chk("zero_cd_pulse", finish_pulse, 1);
    clear = 1; step(); clear = 0;
    set = 1; step();
    chk("rst_pre_sec", sec, 0);
    chk("rst_pre_min", min, 0);
    set = 0; step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      tick    = ($urandom_range(0, 1) == 1);
      enable  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) set = ~set;
      inc_sec = ($urandom_range(0, 2) == 0);
      inc_min = ($urandom_range(0, 2) == 0);
      start   = ($urandom_range(0, 9) == 0);
      clear   = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/timer_mmss.md
# timer_mmss

Parametrised minutes:seconds timer for the VGA monitor datapath, clocked from the system clock with a one-cycle `tick` enable. It counts up as a stopwatch or down as a countdown, in mode `mode`. Field presets are edited by synchronous edge-detected increment inputs, and `finish` flags the terminal value. Its outputs feed the digit/BCD renderer directly.

## Interface
Parameters:
- `W`, 6: bit width of each field
- `SEC_MOD`, 60: seconds field modulus; seconds run 0..SEC_MOD-1
- `MIN_MOD`, 60: minutes field modulus; minutes run 0..MIN_MOD-1

Ports:
- `clk` input 1: system clock; one clock only
- `reset_n` input 1: reset is asynchronous and active-low
- `tick` input 1: one-`clk`-wide count enable, nominally 1 Hz
- `enable` input 1: gates counting; low = pause/hold
- `mode` input 1: 0 = count up (stopwatch), 1 = count down
- `set` input 1: level; high = preset edit
- `inc_sec` input 1: seconds preset increment, rising edge
- `inc_min` input 1: minutes preset increment, rising edge
- `start` input 1: one-cycle start request
- `clear` input 1: one-cycle abort/reload
- `sec` output W: current seconds
- `min` output W: current minutes
- `running` output 1: high in RUN
- `finish` output 1: high while in DONE
- `finish_pulse` output 1: one cycle on entry to DONE

## Operation
- States: IDLE, SET, RUN, DONE.
- Reset:
  - state IDLE
  - presets `pre_sec`/`pre_min` = 0
  - `sec` = `min` = 0
  - `running`, `finish`, `finish_pulse` = 0
- `clear` has top priority in every state:
  - go to IDLE
  - load count = preset when `mode`=1, 0 when `mode`=0
  - presets are kept
- IDLE:
  - `set`=1 -> SET
  - `start`=1 and `enable`=1:
    - `mode`=0: count := 0:00, go to RUN
    - `mode`=1, preset nonzero: count := preset, go to RUN
    - `mode`=1, preset 0:00: go straight to DONE
  - `set` takes priority over `start` in the same cycle.
- SET:
  - `inc_sec` edge: `pre_sec` += 1, wrapping SEC_MOD-1 -> 0 with no carry into minutes.
  - `inc_min` edge: `pre_min` += 1, wrapping MIN_MOD-1 -> 0.
  - Both edges in the same cycle: both fields update.
  - Outputs `sec`/`min` show the preset while in SET.
  - `set`=0 -> IDLE; count := preset (down) or 0 (up).
- RUN, acting only on `tick`=1 with `enable`=1; otherwise hold:
  - Up: seconds += 1; at SEC_MOD-1 seconds wraps to 0 and minutes += 1. From (MIN_MOD-1):(SEC_MOD-1) the count saturates there and the state goes to DONE.
  - Down: seconds -= 1; at 0 seconds reloads SEC_MOD-1 and minutes -= 1. The tick that produces 0:00 moves the state to DONE, with 0:00 displayed.
  - `set`, `inc_*` and `start` are ignored.
- DONE:
  - count frozen, `finish`=1
  - leave only via `clear` or reset
- Increment edges are sampled in SET only. The edge-detect register updates every cycle, so a button held high across entry to SET does not produce an increment.
- Width rule: SEC_MOD, MIN_MOD ≤ 2^W, elaborate-time check. All arithmetic is W-bit with explicit compare-to-limit; no reliance on natural overflow.
- Inputs are already synchronous to `clk`; synchronisers live upstream.

## Timing
- All outputs are registered.
- Count update: `tick` high at edge n -> new `sec`/`min` valid after edge n.
- Increment: `inc_*` low at edge n-1 and high at edge n -> preset updated after edge n+1. One cycle of latency comes from the edge register.
- `finish` and `finish_pulse` rise on the same edge that loads the terminal count. `finish_pulse` falls one edge later.
- `running` tracks the state register with zero extra latency.
- An asynchronous `reset_n` assertion mid-count forces all outputs to their reset values immediately. Deassertion is synchronised externally.

## Structure
- Package `timer_pkg` holds:
  - state encoding constants IDLE/SET/RUN/DONE (2-bit)
  - `MODE_UP`/`MODE_DOWN` constants
- Sub-module `mod_counter`, instantiated twice for seconds and minutes, parameters W and MOD:
  - Inputs: `en`, `up`, `load`, `load_val`.
  - Outputs: `q`, `wrap` (combinational terminal indication: q==MOD-1 when up, q==0 when down).
  - Minutes `en` = seconds `wrap` & seconds `en`.
- The top level holds the FSM, preset registers and edge detectors.

## Test plan
- Set then countdown: in SET, 2 `inc_min` and 3 `inc_sec` edges; `set`=0; `mode`=1; `start`. After 123 ticks, 0:00 shows, `finish`=1 and `finish_pulse` is exactly one cycle wide; the 124th tick changes nothing.
- Up wrap and saturation: `mode`=0 from 0:59, one tick -> 1:00. From 59:59, one tick -> count holds 59:59 and `finish`=1.
- Pause: in RUN, `enable`=0 with 5 ticks applied -> count unchanged; re-enable and 1 tick -> advances by exactly 1.
- Preset wrap: `pre_sec`=59, 1 `inc_sec` edge -> `pre_sec`=0 and `pre_min` unchanged. A held `inc_sec` over 10 cycles gives exactly one increment.
- Priority: `clear` and `tick` in the same cycle in RUN (down, preset 1:30) -> IDLE showing 1:30. `set` and `start` together in IDLE -> SET.
- Reset mid-run at 0:45 -> `sec`=`min`=0, presets 0, `running`=0, `finish`=0, asynchronously before the next `clk` edge. Countdown `start` with preset 0:00 -> DONE next edge.
